// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared instruction constants and pop-count encoding
package fetch_pkg;

    localparam int INSTR_W    = 16;
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 12;

    typedef logic [INSTR_W-1:0] instr_t;

    localparam instr_t NOP = 16'h0000;

    // Number of queued instructions retired by the relayer in one cycle.
    typedef enum logic [1:0] {
        POP_NONE = 2'd0,
        POP_ONE  = 2'd1,
        POP_TWO  = 2'd2
    } pop_t;

    function automatic logic [OPCODE_MSB-OPCODE_LSB:0] opcode_of(input instr_t instr);
        return instr[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_pair_queue_if.sv
// rtl/fetch_pair_queue_if.sv - instruction memory and relay-side signals of the fetch queue
interface fetch_pair_queue_if #(
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16
);
    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;

    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;

    logic              isstall;
    logic              issingleinstr;

    instr_t            instr1_o;
    logic [ADDR_W-1:0] pc1_o;
    instr_t            instr2_o;
    logic [ADDR_W-1:0] pc2_o;
    logic [CW-1:0]     count_o;

    modport master (
        output imem_req, imem_addr,
        output instr1_o, pc1_o, instr2_o, pc2_o, count_o,
        input  imem_rdata, redirect_valid, redirect_pc, isstall, issingleinstr
    );

    modport slave (
        input  imem_req, imem_addr,
        input  instr1_o, pc1_o, instr2_o, pc2_o, count_o,
        output imem_rdata, redirect_valid, redirect_pc, isstall, issingleinstr
    );

endinterface

// File: rtl/instr_ring_buffer.sv
// rtl/instr_ring_buffer.sv - ring of 16-bit instructions with address tags, 2-wide push/peek
module instr_ring_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH  = 8,
    parameter  int ADDR_W = 16,
    localparam int PW     = $clog2(DEPTH),
    localparam int CW     = PW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [1:0]        push_n,
    input  instr_t            push_data0,
    input  logic [ADDR_W-1:0] push_tag0,
    input  instr_t            push_data1,
    input  logic [ADDR_W-1:0] push_tag1,
    input  logic [1:0]        pop_n,
    output instr_t            peek_data0,
    output logic [ADDR_W-1:0] peek_tag0,
    output instr_t            peek_data1,
    output logic [ADDR_W-1:0] peek_tag1,
    output logic [CW-1:0]     count
);

    instr_t            data_q [DEPTH];
    logic [ADDR_W-1:0] tag_q  [DEPTH];

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic [PW-1:0] rd_ptr1;
    logic [PW-1:0] wr_ptr1;

    assign rd_ptr1 = rd_ptr + PW'(1);
    assign wr_ptr1 = wr_ptr + PW'(1);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            rd_ptr  <= rd_ptr + PW'(pop_n);
            wr_ptr  <= wr_ptr + PW'(push_n);
            count_q <= count_q + CW'(push_n) - CW'(pop_n);
        end
    end

    // Payload storage needs no reset: slots beyond count are never shown.
    always_ff @(posedge clk) begin
        if (!rst && !flush) begin
            if (push_n != 2'd0) begin
                data_q[wr_ptr] <= push_data0;
                tag_q[wr_ptr]  <= push_tag0;
            end
            if (push_n == 2'd2) begin
                data_q[wr_ptr1] <= push_data1;
                tag_q[wr_ptr1]  <= push_tag1;
            end
        end
    end

    assign peek_data0 = data_q[rd_ptr];
    assign peek_tag0  = tag_q[rd_ptr];
    assign peek_data1 = data_q[rd_ptr1];
    assign peek_tag1  = tag_q[rd_ptr1];
    assign count      = count_q;

endmodule

// File: rtl/fetch_pair_queue.sv
// rtl/fetch_pair_queue.sv - fetches instruction pairs into a ring and presents two per cycle to the relayer
module fetch_pair_queue
    import fetch_pkg::*;
#(
    parameter int                DEPTH    = 8,
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input logic               clk,
    input logic               rst,
    fetch_pair_queue_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q;
    logic              inflight_q;
    logic              discard_q;

    logic [ADDR_W-1:0] aligned_pc;
    pop_t              pop_req;
    logic [1:0]        pop_n;
    logic [CW:0]       occ_after;
    logic              req;

    logic [1:0]        push_n;
    instr_t            push_data0;
    logic [ADDR_W-1:0] push_tag0;
    instr_t            push_data1;
    logic [ADDR_W-1:0] push_tag1;

    instr_t            peek_data0;
    logic [ADDR_W-1:0] peek_tag0;
    instr_t            peek_data1;
    logic [ADDR_W-1:0] peek_tag1;
    logic [CW-1:0]     count;

    assign aligned_pc = {pc_q[ADDR_W-1:1], 1'b0};

    always_comb begin
        if (bus.isstall) begin
            pop_req = POP_NONE;
        end else if (bus.issingleinstr) begin
            pop_req = POP_ONE;
        end else begin
            pop_req = POP_TWO;
        end
        // Never retire more than is queued; the shortfall positions are NOPs.
        if (CW'(pop_req) > count) begin
            pop_n = count[1:0];
        end else begin
            pop_n = pop_req;
        end
    end

    // Room must exist for a full pair once this cycle's pops are gone.
    always_comb begin
        occ_after = {1'b0, count} - (CW+1)'(pop_n) + (CW+1)'(2);
        req       = !rst && !bus.redirect_valid && !inflight_q && !discard_q
                    && (occ_after <= (CW+1)'(DEPTH));
    end

    assign bus.imem_req  = req;
    assign bus.imem_addr = aligned_pc;

    // An odd fetch address keeps only the upper half of the returned pair.
    always_comb begin
        push_n     = 2'd0;
        push_data0 = bus.imem_rdata[15:0];
        push_tag0  = aligned_pc;
        push_data1 = bus.imem_rdata[31:16];
        push_tag1  = {pc_q[ADDR_W-1:1], 1'b1};
        if (inflight_q) begin
            if (pc_q[0]) begin
                push_n     = 2'd1;
                push_data0 = bus.imem_rdata[31:16];
                push_tag0  = {pc_q[ADDR_W-1:1], 1'b1};
            end else begin
                push_n = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            inflight_q <= 1'b0;
            discard_q  <= 1'b0;
        end else if (bus.redirect_valid) begin
            pc_q       <= bus.redirect_pc;
            discard_q  <= inflight_q;
            inflight_q <= 1'b0;
        end else begin
            if (inflight_q) begin
                pc_q <= aligned_pc + ADDR_W'(2);
            end
            discard_q  <= 1'b0;
            inflight_q <= req;
        end
    end

    instr_ring_buffer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ring (
        .clk        (clk),
        .rst        (rst),
        .flush      (bus.redirect_valid),
        .push_n     (push_n),
        .push_data0 (push_data0),
        .push_tag0  (push_tag0),
        .push_data1 (push_data1),
        .push_tag1  (push_tag1),
        .pop_n      (pop_n),
        .peek_data0 (peek_data0),
        .peek_tag0  (peek_tag0),
        .peek_data1 (peek_data1),
        .peek_tag1  (peek_tag1),
        .count      (count)
    );

    always_comb begin
        bus.instr1_o = NOP;
        bus.pc1_o    = '0;
        bus.instr2_o = NOP;
        bus.pc2_o    = '0;
        if (count != '0) begin
            bus.instr1_o = peek_data0;
            bus.pc1_o    = peek_tag0;
        end
        if (count > CW'(1)) begin
            bus.instr2_o = peek_data1;
            bus.pc2_o    = peek_tag1;
        end
    end

    assign bus.count_o = count;

endmodule
